// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: command op encodings and FSM state type.
package counter_sched_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with wrap,
// returning a one-hot grant and its encoded index.
module sched_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_counter_scheduler.sv
// Round-robin command front-end for a shared wrap-around up/down count register
// with a single tagged, backpressured response channel.
//
// state | meaning
// IDLE  | arbitrating; winner sees req_ready, command latched on handshake
// EXEC  | latched op applied to the count register
// RESP  | response held on rsp_* until rsp_ready
module shared_counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         count,
  output logic                     busy
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               hs;

  sched_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (state_q == IDLE),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign hs = (state_q == IDLE) && (|(req_valid & grant));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_q         <= OP_INC;
      data_q       <= '0;
      id_q         <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      data_q       <= data_d;
      id_q         <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, count ALU and round-robin pointer update.
  always_comb begin
    op_d         = op_q;
    data_d       = data_q;
    id_d         = id_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (hs) begin
      op_d   = req_op[2*grant_idx +: 2];
      data_d = req_data[WIDTH*grant_idx +: WIDTH];
      id_d   = grant_idx;
    end
    if (state_q == EXEC) begin
      case (op_q)
        OP_INC:  count_d = count_q + WIDTH'(1);
        OP_DEC:  count_d = count_q - WIDTH'(1);
        OP_LOAD: count_d = data_q;
        default: count_d = count_q;
      endcase
    end
    if (state_q == RESP && rsp_ready) last_grant_d = id_q;
  end

  always_comb begin
    req_ready = grant;
    rsp_valid = (state_q == RESP);
    rsp_id    = (state_q == RESP) ? id_q : '0;
    rsp_data  = (state_q == RESP) ? count_q : '0;
    count     = count_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_shared_counter_scheduler.sv
// Scoreboard bench for shared_counter_scheduler: directed scenarios plus randomized
// multi-requester traffic checked against a behavioural model.
module tb_shared_counter_scheduler;
  localparam int N = 4;
  localparam int W = 16;
  localparam logic [1:0] INC = 2'b00, DEC = 2'b01, LOAD = 2'b10, READ = 2'b11;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_data;
  logic           rsp_valid, rsp_ready, busy;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data, count;

  shared_counter_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  // Reference model: phase 0 idle, 1 executing, 2 responding.
  int          m_phase = 0;
  logic [W-1:0] m_count = '0;
  int          m_last  = N - 1;
  int          sb_id[$];
  logic [W-1:0] sb_data[$];

  always @(negedge clk) begin
    int win;
    logic [1:0] op;
    logic [W-1:0] d;
    if (reset) begin
      sb_id.delete(); sb_data.delete();
      m_phase = 0; m_count = '0; m_last = N - 1;
    end else begin
      check("busy", busy, m_phase != 0);
      check("rsp_valid", rsp_valid, m_phase == 2);
      if (m_phase != 1) check("count", count, m_count);
      case (m_phase)
        0: begin
          win = -1;
          for (int k = 1; k <= N; k++)
            if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
          check("req_ready_idle", req_ready, (win >= 0) ? (32'd1 << win) : 32'd0);
          if (win >= 0) begin
            op = req_op[2*win +: 2];
            d  = req_data[W*win +: W];
            case (op)
              INC:     m_count = m_count + 1;
              DEC:     m_count = m_count - 1;
              LOAD:    m_count = d;
              default: m_count = m_count;
            endcase
            sb_id.push_back(win);
            sb_data.push_back(m_count);
            m_last  = win;
            m_phase = 1;
          end
        end
        1: begin
          check("req_ready_exec", req_ready, 0);
          m_phase = 2;
        end
        default: begin
          check("req_ready_resp", req_ready, 0);
          if (sb_id.size() > 0) begin
            check("rsp_id", rsp_id, sb_id[0]);
            check("rsp_data", rsp_data, sb_data[0]);
            if (rsp_ready) begin
              void'(sb_id.pop_front());
              void'(sb_data.pop_front());
              m_phase = 0;
            end
          end else begin
            fail("scoreboard_empty");
            m_phase = 0;
          end
        end
      endcase
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] d);
    req_op[2*i +: 2] = op;
    req_data[W*i +: W] = d;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [W-1:0] d);
    logic got = 1'b0;
    set_req(i, op, d);
    req_valid[i] = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = req_ready[i];
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    if (!got) fail("issue_timeout");
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      done = !busy;
      @(posedge clk); #1;
    end
    if (!done) fail("idle_timeout");
  endtask

  // Hold each requester in mask valid until it has been granted once.
  task automatic run_mask(input logic [N-1:0] mask, input bit rnd);
    logic [N-1:0] pending = mask, grabbed;
    for (int i = 0; i < N; i++)
      set_req(i, rnd ? 2'($urandom_range(0, 3)) : INC,
              ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom));
    req_valid = pending;
    for (int k = 0; k < 200 && pending != 0; k++) begin
      @(negedge clk);
      grabbed = req_ready & req_valid;
      @(posedge clk); #1;
      pending &= ~grabbed;
      req_valid = pending;
      if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    if (pending != 0) fail("mask_timeout");
  endtask

  initial begin
    int hs, last_cyc;
    req_valid = '0; req_op = '0; req_data = '0; rsp_ready = 1'b1; reset = 1'b1;
    do_reset();
    @(negedge clk);
    check("reset_count", count, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_busy", busy, 0);
    @(posedge clk); #1;

    // Single INC from requester 0.
    issue(0, INC, '0);
    wait_idle();
    check("inc_count", count, 16'h0001);

    // DEC wrap, then LOAD 0xFFFF and INC wrap.
    do_reset();
    issue(2, DEC, '0);
    wait_idle();
    check("dec_wrap", count, 16'hFFFF);
    issue(1, LOAD, 16'hFFFF);
    wait_idle();
    issue(1, INC, '0);
    wait_idle();
    check("inc_wrap", count, 16'h0000);

    // All requesters valid: grants 0,1,2,3,0 spaced three cycles apart.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, INC, '0);
    req_valid = '1;
    hs = 0; last_cyc = 0;
    for (int c = 0; c < 40 && hs < 5; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        check("rr_order", req_ready, 32'd1 << (hs % N));
        if (hs > 0) check("rr_gap", c - last_cyc, 3);
        last_cyc = c;
        hs++;
      end
      @(posedge clk); #1;
      if (hs == 5) req_valid = '0;
    end
    req_valid = '0;
    if (hs < 5) fail("rr_timeout");
    wait_idle();
    check("rr_count", count, 16'd5);

    // READ from requester 3 stalled by rsp_ready low.
    rsp_ready = 1'b0;
    issue(3, READ, '0);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_id", rsp_id, 3);
    check("stall_data", rsp_data, 16'd5);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during EXEC drops the LOAD and restarts arbitration at requester 0.
    issue(2, LOAD, 16'h1234);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, INC, '0); set_req(2, INC, '0);
    req_valid = 4'b0101;
    @(negedge clk);
    check("post_reset_count", count, 0);
    check("post_reset_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Requester 1 just served, then 1 and 3 compete: 3 wins first.
    issue(1, INC, '0);
    wait_idle();
    req_valid = 4'b1010;
    @(negedge clk);
    check("rr_skip", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    run_mask(4'b1010, 1'b0);
    wait_idle();

    // Randomized traffic with random backpressure.
    repeat (60) begin
      run_mask(N'($urandom_range(1, 15)), 1'b1);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
